// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control unit.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_BRANCH,
    CLS_STORE,
    CLS_LOAD,
    CLS_MOVE,
    CLS_CMP,
    CLS_DP,
    CLS_ILLEGAL
  } cls_t;

  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;

  localparam logic [1:0] EXT_NONE   = 2'd0;
  localparam logic [1:0] EXT_IMM    = 2'd1;
  localparam logic [1:0] EXT_BRANCH = 2'd2;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_ILLEGAL   = 2'd1;
  localparam logic [1:0] FC_FETCH_TMO = 2'd2;
  localparam logic [1:0] FC_DATA_TMO  = 2'd3;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction and data memory handshake bundle between control unit and memories.
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input imem_ack, input dmem_ack);
  modport slave  (input imem_req, input dmem_req, input dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction-class, ALU-op and extend-select decode of the latched fields.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 2,
  parameter int unsigned INST_W = 2
) (
  input  logic [OP_W-1:0]   op,
  input  logic [INST_W-1:0] inst,
  input  logic              immin,
  output cls_t              cls,
  output logic [2:0]        alu_op,
  output logic [1:0]        ext_sel,
  output logic              illegal
);

  logic       high_op;
  logic [1:0] op_lo;
  logic [1:0] inst_lo;

  assign high_op = (op >> 2) != '0;
  assign op_lo   = op[1:0];
  assign inst_lo = inst[1:0];

  always_comb begin
    cls = CLS_ILLEGAL;
    if (!high_op) begin
      unique case (op_lo)
        2'b00: cls = immin ? CLS_BRANCH : CLS_NOP;
        2'b01: cls = CLS_ILLEGAL;
        2'b10: begin
          unique case (inst_lo)
            2'b00: cls = immin ? CLS_ILLEGAL : CLS_STORE;
            2'b01: cls = immin ? CLS_ILLEGAL : CLS_LOAD;
            2'b10: cls = CLS_MOVE;
            default: cls = CLS_CMP;
          endcase
        end
        default: cls = CLS_DP;
      endcase
    end
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      CLS_DP:   alu_op = {1'b0, inst_lo};
      CLS_CMP:  alu_op = ALU_SUB;
      CLS_MOVE: alu_op = ALU_PASS;
      default:  alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    ext_sel = EXT_NONE;
    if (cls == CLS_BRANCH) ext_sel = EXT_BRANCH;
    else if (op_lo[1] && immin) ext_sel = EXT_IMM;
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: fetch/decode/execute/memory/write-back with
// memory handshakes, one-cycle datapath strobes, illegal-op and timeout faults.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 2,
  parameter int unsigned INST_W  = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      stall,
  input  logic [OP_W-1:0]           op_in,
  input  logic [INST_W-1:0]         inst_in,
  input  logic                      immin_in,
  multicycle_control_unit_if.master mem,
  output logic                      wreg,
  output logic                      wpc,
  output logic                      flag_we,
  output logic [1:0]                jmp_f,
  output logic [2:0]                alu_op,
  output logic [1:0]                ext_sel,
  output logic                      busy,
  output logic                      fault,
  output logic [1:0]                fault_code,
  output logic [CNT_W-1:0]          retired
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 2);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [INST_W-1:0]   inst_q;
  logic                immin_q;
  logic                dec_valid;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [1:0]          code_q, code_d;
  cls_t                cls;
  logic [2:0]          dec_alu;
  logic [1:0]          dec_ext;
  logic                illegal;
  logic                tmo_hit;
  logic                retire;
  logic                fetch_latch;

  ctrl_decode #(.OP_W(OP_W), .INST_W(INST_W)) u_decode (
    .op      (op_q),
    .inst    (inst_q),
    .immin   (immin_q),
    .cls     (cls),
    .alu_op  (dec_alu),
    .ext_sel (dec_ext),
    .illegal (illegal)
  );

  // Reaching the limit on a cycle that still has no ack; an ack that cycle wins.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    retire      = 1'b0;
    fetch_latch = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ack) begin
          fetch_latch = 1'b1;
          state_d     = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
          code_d  = FC_FETCH_TMO;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_FAULT;
          code_d  = FC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = S_MEM;
            CLS_MOVE, CLS_DP:    state_d = S_WB;
            default:             retire  = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (cls == CLS_STORE) retire = 1'b1;
          else state_d = S_WB;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
          code_d  = FC_DATA_TMO;
        end
      end
      S_WB:     if (!stall) retire = 1'b1;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      code_q    <= FC_NONE;
      op_q      <= '0;
      inst_q    <= '0;
      immin_q   <= 1'b0;
      dec_valid <= 1'b0;
      tmo_cnt   <= '0;
      retired   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      if (fetch_latch) begin
        op_q      <= op_in;
        inst_q    <= inst_in;
        immin_q   <= immin_in;
        dec_valid <= 1'b1;
      end
      // FETCH and MEM are only ever entered from another state, so any change clears.
      if (state_d != state_q) tmo_cnt <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem.imem_req = (state_q == S_FETCH);
  assign mem.dmem_req = (state_q == S_MEM);
  assign mem.dmem_we  = (state_q == S_MEM) && (cls == CLS_STORE);
  assign wreg         = (state_q == S_WB) && !stall;
  assign wpc          = (state_q == S_EXEC) && !stall && (cls == CLS_BRANCH);
  assign flag_we      = (state_q == S_EXEC) && !stall && (cls == CLS_CMP);
  assign busy         = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault        = (state_q == S_FAULT);
  assign fault_code   = code_q;
  assign jmp_f        = dec_valid ? inst_q[1:0] : '0;
  assign alu_op       = dec_valid ? dec_alu : '0;
  assign ext_sel      = dec_valid ? dec_ext : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, randomized
// phase-level reference model, and hand-written multi-cycle corner sequences.
module tb_multicycle_control_unit;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned INST_W = 2;
  localparam int unsigned TMO   = 4;
  localparam int unsigned CNT_W = 16;

  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;
  localparam int C_NOP = 0, C_BR = 1, C_ST = 2, C_LD = 3, C_MV = 4, C_CMP = 5, C_DP = 6, C_ILL = 7;

  logic clk = 1'b0;
  logic rst, run, stall, immin_in;
  logic [OP_W-1:0] op_in;
  logic [INST_W-1:0] inst_in;
  logic wreg, wpc, flag_we, busy, fault;
  logic [1:0] jmp_f, ext_sel, fault_code;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit_if mif();

  multicycle_control_unit #(.OP_W(OP_W), .INST_W(INST_W), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall),
    .op_in(op_in), .inst_in(inst_in), .immin_in(immin_in),
    .mem(mif),
    .wreg(wreg), .wpc(wpc), .flag_we(flag_we), .jmp_f(jmp_f),
    .alu_op(alu_op), .ext_sel(ext_sel), .busy(busy), .fault(fault),
    .fault_code(fault_code), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  typedef struct {
    logic [1:0] op;
    logic [1:0] inst;
    logic       immin;
    int         n_busy;
    int         n_wreg;
    int         n_wpc;
    int         n_flag;
    int         n_dreq;
    int         n_we;
    logic       chk_dec;
    logic [2:0] alu;
    logic [1:0] ext;
    logic [1:0] fcode;
    int         ret;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {mif.imem_req, mif.dmem_req, mif.dmem_we, wreg, wpc, flag_we, busy, fault};
  endfunction

  function automatic int ref_class(input logic [1:0] op, input logic [1:0] inst, input logic im);
    if (op == 2'b00) return im ? C_BR : C_NOP;
    if (op == 2'b01) return C_ILL;
    if (op == 2'b11) return C_DP;
    if (inst == 2'b00) return im ? C_ILL : C_ST;
    if (inst == 2'b01) return im ? C_ILL : C_LD;
    if (inst == 2'b10) return C_MV;
    return C_CMP;
  endfunction

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; stall = 1'b0;
    op_in = '0; inst_in = '0; immin_in = 1'b0;
    mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nb, nw, np, nf, nd, ne, ni;
    nb = 0; nw = 0; np = 0; nf = 0; nd = 0; ne = 0; ni = 0;
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      mif.imem_ack = mif.imem_req;
      if (mif.imem_req) begin
        op_in = v.op; inst_in = v.inst; immin_in = v.immin; run = 1'b0;
      end
      mif.dmem_ack = mif.dmem_req;
      #1;
      nb += int'(busy); nw += int'(wreg); np += int'(wpc); nf += int'(flag_we);
      nd += int'(mif.dmem_req); ne += int'(mif.dmem_we); ni += int'(mif.imem_req);
    end
    check($sformatf("tbl%0d_busy_cycles", idx), nb, v.n_busy);
    check($sformatf("tbl%0d_wreg", idx), nw, v.n_wreg);
    check($sformatf("tbl%0d_wpc", idx), np, v.n_wpc);
    check($sformatf("tbl%0d_flag_we", idx), nf, v.n_flag);
    check($sformatf("tbl%0d_dmem_req", idx), nd, v.n_dreq);
    check($sformatf("tbl%0d_dmem_we", idx), ne, v.n_we);
    check($sformatf("tbl%0d_imem_req", idx), ni, 1);
    check($sformatf("tbl%0d_fault", idx), fault, v.fcode != 2'd0);
    check($sformatf("tbl%0d_fault_code", idx), fault_code, v.fcode);
    check($sformatf("tbl%0d_retired", idx), retired, v.ret);
    if (v.chk_dec)
      check($sformatf("tbl%0d_decode", idx), {alu_op, ext_sel, jmp_f}, {v.alu, v.ext, v.inst});
  endtask

  task automatic rand_run(input int n_instr);
    int ph[$];
    int cls, cur, fdel, ddel, fw, dw, exp_ret;
    logic [1:0] op, inst, e_ext;
    logic [2:0] e_alu;
    logic im, s, ia, da;
    logic [7:0] exp;
    exp_ret = 0;
    do_reset();
    run = 1'b1;
    for (int n = 0; n < n_instr; n++) begin
      do begin
        op = 2'($urandom); inst = 2'($urandom); im = 1'($urandom);
        cls = ref_class(op, inst, im);
      end while (cls == C_ILL);
      e_alu = (cls == C_DP) ? {1'b0, inst} : (cls == C_CMP) ? 3'b101 :
              (cls == C_MV) ? 3'b110 : 3'b100;
      e_ext = (cls == C_BR) ? 2'd2 : (op[1] && im) ? 2'd1 : 2'd0;
      fdel = $urandom_range(0, 3); ddel = $urandom_range(0, 3);
      fw = 0; dw = 0;
      ph = {P_F, P_D, P_E};
      if (cls == C_LD || cls == C_ST) ph.push_back(P_M);
      if (cls == C_LD || cls == C_MV || cls == C_DP) ph.push_back(P_W);
      while (ph.size() > 0) begin
        @(negedge clk);
        cur = ph[0];
        s = ($urandom_range(0, 3) == 0);
        stall = s;
        ia = (cur == P_F) && (fw == fdel);
        mif.imem_ack = ia;
        if (ia) begin
          op_in = op; inst_in = inst; immin_in = im;
        end else begin
          op_in = 2'($urandom); inst_in = 2'($urandom); immin_in = 1'($urandom);
        end
        da = (cur == P_M) && (dw == ddel);
        mif.dmem_ack = da;
        #1;
        exp = {cur == P_F, cur == P_M, cur == P_M && cls == C_ST, cur == P_W && !s,
               cur == P_E && cls == C_BR && !s, cur == P_E && cls == C_CMP && !s, 1'b1, 1'b0};
        check("rnd_outputs", obs(), exp);
        check("rnd_retired", retired, exp_ret);
        if (cur != P_F) check("rnd_decode", {alu_op, ext_sel, jmp_f}, {e_alu, e_ext, inst});
        case (cur)
          P_F: if (ia) void'(ph.pop_front()); else fw++;
          P_M: if (da) void'(ph.pop_front()); else dw++;
          P_D: void'(ph.pop_front());
          default: if (!s) void'(ph.pop_front());
        endcase
      end
      exp_ret++;
    end
    stall = 1'b0; mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
    @(negedge clk); #1;
    check("rnd_final_retired", retired, exp_ret);
    check("pre_rst_imem_req", mif.imem_req, 1'b1);
  endtask

  initial begin
    vec_t tbl[13];
    int cnt, pos, n;

    // Reset state
    rst = 1'b1; run = 1'b0; stall = 1'b0; op_in = '0; inst_in = '0; immin_in = 1'b0;
    mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
    @(negedge clk); #1;
    check("reset_outputs", obs(), 8'h00);
    check("reset_fields", {alu_op, ext_sel, jmp_f, fault_code}, 9'h000);
    check("reset_retired", retired, 0);

    //           op     inst  im   busy wr pc fl dq we dec  alu    ext fc  ret
    tbl[0]  = '{2'b11, 2'b10, 1'b0, 4, 1, 0, 0, 0, 0, 1'b1, 3'b010, 2'd0, 2'd0, 1};
    tbl[1]  = '{2'b11, 2'b01, 1'b1, 4, 1, 0, 0, 0, 0, 1'b1, 3'b001, 2'd1, 2'd0, 1};
    tbl[2]  = '{2'b00, 2'b11, 1'b1, 3, 0, 1, 0, 0, 0, 1'b1, 3'b100, 2'd2, 2'd0, 1};
    tbl[3]  = '{2'b00, 2'b01, 1'b0, 3, 0, 0, 0, 0, 0, 1'b1, 3'b100, 2'd0, 2'd0, 1};
    tbl[4]  = '{2'b10, 2'b11, 1'b0, 3, 0, 0, 1, 0, 0, 1'b1, 3'b101, 2'd0, 2'd0, 1};
    tbl[5]  = '{2'b10, 2'b10, 1'b1, 4, 1, 0, 0, 0, 0, 1'b1, 3'b110, 2'd1, 2'd0, 1};
    tbl[6]  = '{2'b10, 2'b00, 1'b0, 4, 0, 0, 0, 1, 1, 1'b1, 3'b100, 2'd0, 2'd0, 1};
    tbl[7]  = '{2'b10, 2'b01, 1'b0, 5, 1, 0, 0, 1, 0, 1'b1, 3'b100, 2'd0, 2'd0, 1};
    tbl[8]  = '{2'b01, 2'b00, 1'b0, 2, 0, 0, 0, 0, 0, 1'b0, 3'b000, 2'd0, 2'd1, 0};
    tbl[9]  = '{2'b10, 2'b01, 1'b1, 2, 0, 0, 0, 0, 0, 1'b0, 3'b000, 2'd0, 2'd1, 0};
    tbl[10] = '{2'b10, 2'b00, 1'b1, 2, 0, 0, 0, 0, 0, 1'b0, 3'b000, 2'd0, 2'd1, 0};
    tbl[11] = '{2'b10, 2'b11, 1'b1, 3, 0, 0, 1, 0, 0, 1'b1, 3'b101, 2'd1, 2'd0, 1};
    tbl[12] = '{2'b00, 2'b10, 1'b0, 3, 0, 0, 0, 0, 0, 1'b1, 3'b100, 2'd0, 2'd0, 1};
    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

    // Fetch timeout: no ack ever
    do_reset(); run = 1'b1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      cnt += int'(mif.imem_req);
    end
    check("fetch_tmo_req_cycles", cnt, TMO);
    check("fetch_tmo_fault", {fault, fault_code, busy}, {1'b1, 2'd2, 1'b0});

    // Ack on the last allowed fetch cycle wins over the timeout
    do_reset(); run = 1'b1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mif.imem_ack = 1'b0;
      if (mif.imem_req) begin
        cnt++;
        if (cnt == TMO) begin
          mif.imem_ack = 1'b1; op_in = 2'b00; inst_in = 2'b00; immin_in = 1'b0; run = 1'b0;
        end
      end
      #1;
    end
    check("fetch_ack_at_limit_req_cycles", cnt, TMO);
    check("fetch_ack_at_limit_fault", fault, 1'b0);
    check("fetch_ack_at_limit_retired", retired, 1);

    // Load: ack on 4th MEM cycle, then data timeout with no ack
    for (int t = 0; t < 2; t++) begin
      do_reset(); run = 1'b1; cnt = 0; n = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        mif.imem_ack = mif.imem_req;
        if (mif.imem_req) begin
          op_in = 2'b10; inst_in = 2'b01; immin_in = 1'b0; run = 1'b0;
        end
        mif.dmem_ack = 1'b0;
        if (mif.dmem_req) begin
          cnt++;
          if (t == 0 && cnt == 4) mif.dmem_ack = 1'b1;
          if (mif.dmem_we) n = 99;
        end
        #1;
        if (wreg) n++;
      end
      check($sformatf("load%0d_dmem_req_cycles", t), cnt, 4);
      check($sformatf("load%0d_wreg_pulses", t), n, (t == 0) ? 1 : 0);
      check($sformatf("load%0d_fault", t), {fault, fault_code}, (t == 0) ? 3'b000 : 3'b111);
      check($sformatf("load%0d_retired", t), retired, (t == 0) ? 1 : 0);
    end

    // Stall held two cycles in WB delays wreg, still one cycle wide
    do_reset(); run = 1'b1; n = 0; pos = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mif.imem_ack = mif.imem_req;
      if (mif.imem_req) begin
        op_in = 2'b11; inst_in = 2'b00; immin_in = 1'b0; run = 1'b0;
      end
      stall = (c == 4 || c == 5);
      #1;
      if (wreg) begin n++; pos = c; end
    end
    stall = 1'b0;
    check("stall_wb_wreg_count", n, 1);
    check("stall_wb_wreg_cycle", pos, 6);
    check("stall_wb_retired", retired, 1);

    // run drops during EXEC: instruction completes, then IDLE
    do_reset(); run = 1'b1; cnt = 0; pos = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mif.imem_ack = mif.imem_req;
      if (mif.imem_req) begin
        op_in = 2'b11; inst_in = 2'b11; immin_in = 1'b1;
      end
      if (c == 3) run = 1'b0;
      #1;
      cnt += int'(mif.imem_req);
      if (wreg) pos = c;
    end
    check("run_drop_fetches", cnt, 1);
    check("run_drop_wreg_cycle", pos, 4);
    check("run_drop_idle", {busy, fault}, 2'b10 & 2'b00);
    check("run_drop_retired", retired, 1);

    // Illegal stays in FAULT with run asserted, no requests or strobes
    do_reset(); run = 1'b1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mif.imem_ack = mif.imem_req;
      if (mif.imem_req) begin
        op_in = 2'b01; inst_in = 2'b10; immin_in = 1'b0;
      end
      #1;
      if (c >= 3 && obs() != 8'h01) cnt++;
    end
    check("illegal_hold_bad_cycles", cnt, 0);
    check("illegal_hold_code", fault_code, 2'd1);

    // Randomized run against the phase-level model, then async reset mid-fetch
    rand_run(40);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_outputs", obs(), 8'h00);
    check("async_rst_fields", {alu_op, ext_sel, jmp_f, fault_code}, 9'h000);
    check("async_rst_retired", retired, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised, sequential successor to the CPU's single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. It handles the instruction and data memory handshakes, issues one-cycle write strobes to the register file, PC and condition flags, and detects illegal encodings and memory timeouts. It sits between the instruction/data memory ports and the datapath in the CPU.

## Interface
Parameters:
- OP_W, 2, opcode field width (bits above the low 2 bits of `op_in` must be zero, otherwise illegal)
- INST_W, 2, sub-instruction field width (low 2 bits of `inst_in` drive `jmp_f`)
- TIMEOUT, 16, memory-wait limit in cycles; 0 disables the timeout
- CNT_W, 16, retired-instruction counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- run  in  1  allow new instruction fetches
- stall  in  1  datapath hazard; holds EXEC/WB
- op_in  in  OP_W  opcode from instruction memory
- inst_in  in  INST_W  sub-instruction field
- immin_in  in  1  immediate/modifier bit
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  store (1) / load (0)
- dmem_ack  in  1  data access complete
- wreg  out  1  register-file write strobe
- wpc  out  1  PC load strobe
- flag_we  out  1  condition-flag write strobe
- jmp_f  out  2  jump condition select
- alu_op  out  3  ALU operation
- ext_sel  out  2  immediate-extend select
- busy  out  1  high in any state except IDLE/FAULT
- fault  out  1  sticky fault
- fault_code  out  2  0 none, 1 illegal, 2 fetch timeout, 3 data timeout
- retired  out  CNT_W  completed-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- On reset: state IDLE. All outputs 0, including `retired`, the decode register and the timeout counter.
- IDLE → FETCH when `run`=1.
- FETCH: `imem_req`=1. On `imem_ack`, latch `op_in`/`inst_in`/`immin_in` into the decode register, then go to DECODE.
- DECODE: exactly one cycle, then EXEC. Illegal encodings go to FAULT (code 1) instead.
- Classes are decoded from the latched fields:
  - op 00, immin 1: branch.
  - op 00, immin 0: NOP.
  - op 01: illegal.
  - op 10, inst 00: store. Illegal if immin=1.
  - op 10, inst 01: load. Illegal if immin=1.
  - op 10, inst 10: move.
  - op 10, inst 11: compare.
  - op 11: data-processing.
- EXEC behaviour by class:
  - Branch: `wpc` pulse, then retire.
  - NOP: retire.
  - Compare: `flag_we` pulse, then retire.
  - Load/store: go to MEM.
  - Move/data-processing: go to WB.
- MEM: `dmem_req`=1 and `dmem_we`=store. On `dmem_ack`, a store retires and a load goes to WB.
- WB: `wreg` pulse, then retire.
- Retire: increment `retired` (wraps modulo 2^CNT_W). Go to FETCH if `run`=1, otherwise IDLE.
- `stall`=1 in EXEC or WB holds the state and suppresses the strobes. It has no effect in other states.
- `alu_op`, `ext_sel` and `jmp_f` are driven from the decode register and are constant from DECODE until the next fetch latch.
- `jmp_f` = latched inst[1:0].
- `alu_op`:
  - Data-processing: {0, inst}.
  - Load/store/branch/NOP: ADD (100).
  - Compare: SUB (101).
  - Move: PASS (110).
- `ext_sel`:
  - Branch: 2.
  - Op 10 or op 11 with immin=1: 1.
  - Otherwise: 0.
- FAULT: all strobes and requests are 0. The state is held until `rst`.

## Timing
- Minimum latency: NOP/branch/compare take 3 cycles (FETCH, DECODE, EXEC), move/data-processing take 4, and a load takes 5, all with zero-wait acks.
- Strobes are exactly one cycle wide and are registered-state decodes (Moore).
- The timeout counter clears on entry to FETCH/MEM and counts each cycle without an ack.
- When the counter reaches TIMEOUT, go to FAULT with code 2 (FETCH) or 3 (MEM). An ack in that same cycle wins.
- `run` falling mid-instruction completes the instruction, then goes to IDLE.
- `rst` mid-operation returns to IDLE immediately and abandons any pending request.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - the class enum;
  - ALU codes ADD/SUB/PASS;
  - extend codes;
  - fault codes.
- Sub-module `ctrl_decode` is the combinational class/`alu_op`/`ext_sel`/illegal decode from the latched fields. Instantiate it once.

## Test plan
- Reset, then `run`=1, fetch op=11 inst=10 immin=0 with immediate acks → `wreg` pulses on cycle 4, `alu_op`=010, `retired`=1.
- Load (op=10 inst=01 immin=0) with `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, then `wreg`, then `retired` increments.
- Branch op=00 immin=1 inst=11 → `wpc` pulse in EXEC, `jmp_f`=11, `ext_sel`=2.
- Illegal op=01, and load with immin=1 → `fault`=1, `fault_code`=1, no strobes, held until `rst`.
- TIMEOUT=4 with `imem_ack` never asserted → FAULT with code 2 after 4 cycles. Repeat with the ack on cycle 4 → no fault.
- `stall` held 2 cycles in WB → `wreg` delayed 2 cycles and still one cycle wide. Drop `run` during EXEC → retire, then IDLE.
